// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control sequencer for a multi-cycle MIPS-subset datapath. It steps each
// instruction through fetch, decode, execute, memory and write-back, and drives
// every datapath select and write strobe. Memory accesses use a mem_ready
// handshake, so memory latency can vary. An unknown opcode or R-type funct
// enters a trap state.
//
// Parameters:
//   ALU_CTRL_W   width of alu_control
//   NUM_ALU_OPS  R-type funct values 0..NUM_ALU_OPS-1 are legal and map
//                directly onto alu_control
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode, funct     IR fields; stable from DECODE until the next FETCH
//   mem_ready         memory completes the current access this cycle
//   iord              memory address select (0 PC, 1 ALUOut)
//   mem_read/write    memory requests, held through wait cycles
//   ir_write          IR load strobe
//   pc_write          unconditional PC load
//   branch/branch_ne  conditional PC load on zero / not zero
//   pc_src            00 ALU, 01 ALUOut, 10 jump target, 11 trap vector
//   alu_control       ALU operation (0 add, 1 sub, 2 and, 3 or, ...)
//   alu_src_a/b       ALU operand selects
//   imm_zext          zero-extend the immediate
//   reg_write         register file write
//   reg_dst           00 rt, 01 rd, 10 r31
//   mem2reg           00 ALUOut, 01 MDR, 10 PC
//   illegal           trap indicator
//   state             current state code, for debug
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int ALU_CTRL_W  = 4,
    parameter int NUM_ALU_OPS = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  branch,
    output logic                  branch_ne,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  imm_zext,
    output logic                  reg_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem2reg,
    output logic                  illegal,
    output logic [3:0]            state
);

    if (NUM_ALU_OPS > 2 ** ALU_CTRL_W) begin : g_bad_params
        $error("NUM_ALU_OPS does not fit in ALU_CTRL_W bits");
    end

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);

    state_t state_q;
    state_t state_d;

    logic                  funct_legal;
    logic [ALU_CTRL_W-1:0] alu_funct;
    logic [ALU_CTRL_W-1:0] alu_imm;
    logic                  zext_imm;

    assign funct_legal = (32'(funct) < NUM_ALU_OPS);
    assign alu_funct   = ALU_CTRL_W'(funct);

    // Immediate-class ALU op and extension, shared by IMMEX and IMMWB so the
    // write-back cycle presents the same values as the execute cycle.
    always_comb begin
        alu_imm  = ALU_ADD;
        zext_imm = 1'b0;
        case (opcode)
            OP_ANDI: begin alu_imm = ALU_AND; zext_imm = 1'b1; end
            OP_ORI:  begin alu_imm = ALU_OR;  zext_imm = 1'b1; end
            default: begin alu_imm = ALU_ADD; zext_imm = 1'b0; end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // NOTE: each combinational block assigns every output a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_RTYPE:                 state_d = funct_legal ? S_EXEC : S_TRAP;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
                    OP_J, OP_JAL:             state_d = S_JUMP;
                    default:                  state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if      (opcode == OP_LW) state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IMMEX:  state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs decode from the current state. During reset the state register
    // already reads FETCH, so everything is also gated off by rst_n to keep
    // the FETCH request and mem_ready-qualified strobes quiet.
    always_comb begin
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        pc_src      = 2'b00;
        alu_control = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        imm_zext    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        mem2reg     = 2'b00;
        illegal     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    reg_write = 1'b1;
                    mem2reg   = 2'b01;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a   = 1'b1;
                    alu_control = alu_funct;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_SUB;
                    pc_src      = 2'b01;
                    branch      = (opcode == OP_BEQ);
                    branch_ne   = (opcode == OP_BNE);
                end
                S_IMMEX: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = alu_imm;
                    imm_zext    = zext_imm;
                end
                S_IMMWB: begin
                    reg_write   = 1'b1;
                    alu_control = alu_imm;
                    imm_zext    = zext_imm;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                    if (opcode == OP_JAL) begin
                        reg_write = 1'b1;
                        reg_dst   = 2'b10;
                        mem2reg   = 2'b10;
                    end
                end
                S_TRAP: begin
                    illegal  = 1'b1;
                    pc_src   = 2'b11;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule
